// File: rtl/beam_pwr_sort_top16.sv
// Streaming top-16 beam power sorter: one beat per clock, single-cycle parallel insert into a descending list.
// eop loads the result registers; o_sort_sop pulses the next cycle and the bundle holds until the next packet ends.
module beam_pwr_sort_top16 #(
    parameter int NUM_BEAMS = 64,
    parameter int PWR_WIDTH = 32
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_pwr_vld,
    input  logic                       i_pwr_sop,
    input  logic                       i_pwr_eop,
    input  logic [PWR_WIDTH-1:0]       i_pwr,
    input  logic [7:0]                 i_pwr_idx,
    input  logic                       i_rbg_load,
    output logic [15:0][PWR_WIDTH-1:0] o_sort_pwr,
    output logic [15:0][7:0]           o_sort_idx,
    output logic [4:0]                 o_sort_cnt,
    output logic                       o_sort_sop,
    output logic                       o_rbg_load,
    output logic                       o_err
);
    localparam int CW = ($clog2(NUM_BEAMS + 1) > 5) ? $clog2(NUM_BEAMS + 1) : 5;
    localparam logic [CW-1:0] CNT_MAX = CW'(NUM_BEAMS);
    localparam logic [CW-1:0] SLOTS   = CW'(16);

    typedef enum logic {S_IDLE = 1'b0, S_ACC = 1'b1} state_t;
    state_t state_q, state_d;

    logic [CW-1:0]              cnt_q, cnt_d;
    logic [15:0][PWR_WIDTH-1:0] lst_pwr_q, lst_pwr_d, ins_pwr;
    logic [15:0][7:0]           lst_idx_q, lst_idx_d, ins_idx;
    logic [15:0]                lst_used_q, lst_used_d, ins_used, base_used, gt;

    logic [15:0][PWR_WIDTH-1:0] sort_pwr_q, sort_pwr_d;
    logic [15:0][7:0]           sort_idx_q, sort_idx_d;
    logic [4:0]                 sort_cnt_q, sort_cnt_d;
    logic                       sort_sop_q, sort_sop_d;
    logic                       rbg_load_q, rbg_load_d;
    logic                       err_q, err_d;

    logic accept, err, complete;

    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (i_pwr_vld) begin
            if (i_pwr_sop)                           state_d = i_pwr_eop ? S_IDLE : S_ACC;
            else if (state_q == S_ACC && i_pwr_eop)  state_d = S_IDLE;
        end
    end

    // An eop beat dropped for overflow still completes the packet.
    always_comb begin
        accept   = 1'b0;
        err      = 1'b0;
        complete = 1'b0;
        if (i_pwr_vld) begin
            if (i_pwr_sop) begin
                accept   = 1'b1;
                err      = (state_q == S_ACC);
                complete = i_pwr_eop;
            end else if (state_q == S_IDLE) begin
                err = 1'b1;
            end else begin
                accept   = (cnt_q < CNT_MAX);
                err      = (cnt_q >= CNT_MAX);
                complete = i_pwr_eop;
            end
        end
    end

    // gt is monotonic over the slots, so the new beat lands where gt first rises and everything below shifts down.
    always_comb begin
        base_used = i_pwr_sop ? '0 : lst_used_q;
        for (int k = 0; k < 16; k++) gt[k] = !base_used[k] || (i_pwr > lst_pwr_q[k]);
        ins_pwr  = lst_pwr_q;
        ins_idx  = lst_idx_q;
        ins_used = base_used;
        if (gt[0]) begin
            ins_pwr[0]  = i_pwr;
            ins_idx[0]  = i_pwr_idx;
            ins_used[0] = 1'b1;
        end
        for (int k = 1; k < 16; k++) begin
            if (gt[k] && !gt[k-1]) begin
                ins_pwr[k]  = i_pwr;
                ins_idx[k]  = i_pwr_idx;
                ins_used[k] = 1'b1;
            end else if (gt[k]) begin
                ins_pwr[k]  = lst_pwr_q[k-1];
                ins_idx[k]  = lst_idx_q[k-1];
                ins_used[k] = base_used[k-1];
            end
        end
    end

    always_comb begin
        lst_pwr_d  = lst_pwr_q;
        lst_idx_d  = lst_idx_q;
        lst_used_d = lst_used_q;
        cnt_d      = cnt_q;
        if (accept) begin
            lst_pwr_d  = ins_pwr;
            lst_idx_d  = ins_idx;
            lst_used_d = ins_used;
            cnt_d      = i_pwr_sop ? CW'(1) : cnt_q + CW'(1);
        end
        sort_pwr_d = sort_pwr_q;
        sort_idx_d = sort_idx_q;
        sort_cnt_d = sort_cnt_q;
        rbg_load_d = rbg_load_q;
        sort_sop_d = complete;
        err_d      = err;
        if (complete) begin
            for (int k = 0; k < 16; k++) begin
                sort_pwr_d[k] = lst_used_d[k] ? lst_pwr_d[k] : '0;
                sort_idx_d[k] = lst_used_d[k] ? lst_idx_d[k] : 8'hFF;
            end
            sort_cnt_d = (cnt_d > SLOTS) ? 5'd16 : cnt_d[4:0];
            rbg_load_d = i_rbg_load;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q      <= '0;
            lst_pwr_q  <= '0;
            lst_idx_q  <= '0;
            lst_used_q <= '0;
            sort_pwr_q <= '0;
            sort_idx_q <= '0;
            sort_cnt_q <= '0;
            sort_sop_q <= 1'b0;
            rbg_load_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            lst_pwr_q  <= lst_pwr_d;
            lst_idx_q  <= lst_idx_d;
            lst_used_q <= lst_used_d;
            sort_pwr_q <= sort_pwr_d;
            sort_idx_q <= sort_idx_d;
            sort_cnt_q <= sort_cnt_d;
            sort_sop_q <= sort_sop_d;
            rbg_load_q <= rbg_load_d;
            err_q      <= err_d;
        end
    end

    assign o_sort_pwr = sort_pwr_q;
    assign o_sort_idx = sort_idx_q;
    assign o_sort_cnt = sort_cnt_q;
    assign o_sort_sop = sort_sop_q;
    assign o_rbg_load = rbg_load_q;
    assign o_err      = err_q;
endmodule

// File: tb/tb_beam_pwr_sort_top16.sv
// Bench for beam_pwr_sort_top16: table vectors, directed corner sequences and random packets
// checked every cycle against a queue-and-select reference model of the sorter.
module tb_beam_pwr_sort_top16;
    localparam int NB = 64;
    localparam int PW = 32;

    logic                i_clk = 1'b0;
    logic                i_reset = 1'b0;
    logic                i_pwr_vld = 1'b0, i_pwr_sop = 1'b0, i_pwr_eop = 1'b0;
    logic [PW-1:0]       i_pwr = '0;
    logic [7:0]          i_pwr_idx = '0;
    logic                i_rbg_load = 1'b0;
    logic [15:0][PW-1:0] o_sort_pwr;
    logic [15:0][7:0]    o_sort_idx;
    logic [4:0]          o_sort_cnt;
    logic                o_sort_sop, o_rbg_load, o_err;

    always #5 i_clk = ~i_clk;

    beam_pwr_sort_top16 #(.NUM_BEAMS(NB), .PWR_WIDTH(PW)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_pwr_vld(i_pwr_vld), .i_pwr_sop(i_pwr_sop),
        .i_pwr_eop(i_pwr_eop), .i_pwr(i_pwr), .i_pwr_idx(i_pwr_idx), .i_rbg_load(i_rbg_load),
        .o_sort_pwr(o_sort_pwr), .o_sort_idx(o_sort_idx), .o_sort_cnt(o_sort_cnt),
        .o_sort_sop(o_sort_sop), .o_rbg_load(o_rbg_load), .o_err(o_err)
    );

    int checks = 0;
    int errors = 0;

    typedef struct { logic [31:0] pwr; logic [7:0] idx; } beat_t;
    beat_t m_q[$];
    bit    m_in = 1'b0;

    logic                exp_err = 1'b0, exp_sop = 1'b0;
    logic [15:0][PW-1:0] e_pwr = '0;
    logic [15:0][7:0]    e_idx = '0;
    logic [4:0]          e_cnt = '0;
    logic                e_rbg = 1'b0;

    typedef struct { logic [31:0] in_pwr; logic [7:0] in_idx; logic [31:0] exp_pwr; logic [7:0] exp_idx; } vec_t;
    vec_t tbl [16];
    int   tin_pwr [10] = '{7, 3, 9, 1, 9, 0, 2, 8, 4, 6};
    int   tex_pwr [10] = '{9, 9, 8, 7, 6, 4, 3, 2, 1, 0};
    int   tex_idx [10] = '{2, 4, 7, 0, 9, 8, 1, 6, 3, 5};

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Result = the 16 largest accepted beats; among equal powers the earlier arrival wins.
    function automatic void model_finish(input logic rbg);
        bit taken [NB];
        int n;
        n = m_q.size();
        for (int j = 0; j < NB; j++) taken[j] = 1'b0;
        for (int s = 0; s < 16; s++) begin
            int best;
            best = -1;
            for (int j = 0; j < n; j++)
                if (!taken[j] && (best < 0 || m_q[j].pwr > m_q[best].pwr)) best = j;
            if (best >= 0) begin
                taken[best] = 1'b1;
                e_pwr[s] = m_q[best].pwr;
                e_idx[s] = m_q[best].idx;
            end else begin
                e_pwr[s] = '0;
                e_idx[s] = 8'hFF;
            end
        end
        e_cnt   = (n > 16) ? 5'd16 : 5'(n);
        e_rbg   = rbg;
        exp_sop = 1'b1;
    endfunction

    function automatic void model_step(input logic vld, input logic sop, input logic eop,
                                       input logic [31:0] pwr, input logic [7:0] idx, input logic rbg);
        beat_t b;
        b.pwr   = pwr;
        b.idx   = idx;
        exp_err = 1'b0;
        exp_sop = 1'b0;
        if (vld) begin
            if (sop) begin
                exp_err = m_in;
                m_q.delete();
                m_q.push_back(b);
                m_in = !eop;
                if (eop) model_finish(rbg);
            end else if (!m_in) begin
                exp_err = 1'b1;
            end else begin
                if (m_q.size() < NB) m_q.push_back(b);
                else                 exp_err = 1'b1;
                if (eop) begin
                    m_in = 1'b0;
                    model_finish(rbg);
                end
            end
        end
    endfunction

    function automatic void model_reset();
        m_in = 1'b0;
        m_q.delete();
        e_pwr = '0; e_idx = '0; e_cnt = '0; e_rbg = 1'b0;
        exp_err = 1'b0; exp_sop = 1'b0;
    endfunction

    task automatic drive(input logic vld, input logic sop, input logic eop, input logic [31:0] pwr,
                         input logic [7:0] idx, input logic rbg, input logic rst);
        i_reset = rst; i_pwr_vld = vld; i_pwr_sop = sop; i_pwr_eop = eop;
        i_pwr = pwr; i_pwr_idx = idx; i_rbg_load = rbg;
        if (rst) model_reset();
        else     model_step(vld, sop, eop, pwr, idx, rbg);
        @(negedge i_clk);
        chk("err",      512'(o_err),      512'(exp_err));
        chk("sort_sop", 512'(o_sort_sop), 512'(exp_sop));
        chk("sort_pwr", 512'(o_sort_pwr), 512'(e_pwr));
        chk("sort_idx", 512'(o_sort_idx), 512'(e_idx));
        chk("sort_cnt", 512'(o_sort_cnt), 512'(e_cnt));
        chk("rbg_load", 512'(o_rbg_load), 512'(e_rbg));
        i_reset = 1'b0; i_pwr_vld = 1'b0; i_pwr_sop = 1'b0; i_pwr_eop = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            tbl[k].in_pwr  = (k < 10) ? 32'(tin_pwr[k]) : 32'd0;
            tbl[k].in_idx  = 8'(k);
            tbl[k].exp_pwr = (k < 10) ? 32'(tex_pwr[k]) : 32'd0;
            tbl[k].exp_idx = (k < 10) ? 8'(tex_idx[k]) : 8'hFF;
        end

        drive(1'b1, 1'b1, 1'b0, 32'd55, 8'd1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 8'd0, 1'b0, 1'b1);
        chk("reset_idx_zero", 512'(o_sort_idx), 512'd0);

        for (int k = 0; k < 10; k++)
            drive(1'b1, k == 0, k == 9, tbl[k].in_pwr, tbl[k].in_idx, 1'b1, 1'b0);
        for (int s = 0; s < 16; s++) begin
            chk($sformatf("short_pwr%0d", s), 512'(o_sort_pwr[s]), 512'(tbl[s].exp_pwr));
            chk($sformatf("short_idx%0d", s), 512'(o_sort_idx[s]), 512'(tbl[s].exp_idx));
        end
        chk("short_cnt", 512'(o_sort_cnt), 512'd10);

        for (int k = 0; k < 64; k++)
            drive(1'b1, k == 0, k == 63, 32'(100 * k), 8'(k), 1'b1, 1'b0);
        chk("asc_pwr0",  512'(o_sort_pwr[0]),  512'd6300);
        chk("asc_idx0",  512'(o_sort_idx[0]),  512'd63);
        chk("asc_pwr15", 512'(o_sort_pwr[15]), 512'd4800);
        chk("asc_idx15", 512'(o_sort_idx[15]), 512'd48);
        chk("asc_cnt",   512'(o_sort_cnt),     512'd16);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 8'd0, 1'b0, 1'b0);

        for (int k = 0; k < 20; k++)
            drive(1'b1, k == 0, k == 19, 32'd5, 8'(k), 1'b0, 1'b0);
        for (int s = 0; s < 16; s++)
            chk($sformatf("tie_idx%0d", s), 512'(o_sort_idx[s]), 512'(s));

        for (int k = 0; k < 5; k++)
            drive(1'b1, k == 0, 1'b0, 32'(1000 + k), 8'(k), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++)
            drive(1'b1, k == 0, k == 2, 32'(k + 1), 8'(100 + k), 1'b1, 1'b0);
        chk("restart_cnt",  512'(o_sort_cnt),    512'd3);
        chk("restart_pwr0", 512'(o_sort_pwr[0]), 512'd3);

        drive(1'b1, 1'b0, 1'b0, 32'd999, 8'd7, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 32'd999, 8'd8, 1'b0, 1'b0);
        chk("idle_stray_hold", 512'(o_sort_cnt), 512'd3);

        for (int k = 0; k < 70; k++)
            drive(1'b1, k == 0, k == 69, 32'(k), 8'(k), 1'b1, 1'b0);
        chk("ovf_pwr0", 512'(o_sort_pwr[0]), 512'd63);
        chk("ovf_cnt",  512'(o_sort_cnt),    512'd16);

        for (int k = 0; k < 5; k++)
            drive(1'b1, k == 0, k == 4, 32'(50 - k), 8'(k), 1'b1, 1'b0);
        chk("b2b_rbg_a", 512'(o_rbg_load), 512'd1);
        for (int k = 0; k < 4; k++)
            drive(1'b1, k == 0, k == 3, 32'(200 + k), 8'(20 + k), 1'b0, 1'b0);
        chk("b2b_rbg_b",  512'(o_rbg_load),    512'd0);
        chk("b2b_pwr0_b", 512'(o_sort_pwr[0]), 512'd203);

        for (int k = 0; k < 29; k++)
            drive(1'b1, k == 0, 1'b0, 32'($urandom), 8'(k), 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 32'd77, 8'd29, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 8'd0, 1'b0, 1'b0);
        chk("rst_mid_pwr", 512'(o_sort_pwr), 512'd0);
        for (int k = 0; k < 20; k++)
            drive(1'b1, k == 0, k == 19, 32'($urandom_range(0, 15)), 8'(k), 1'b1, 1'b0);

        for (int p = 0; p < 40; p++) begin
            int len;
            int gap;
            bit wide;
            len  = $urandom_range(1, 72);
            gap  = $urandom_range(0, 2);
            wide = 1'($urandom_range(0, 1));
            for (int g = 0; g < gap; g++)
                drive($urandom_range(0, 5) == 0, 1'b0, 1'($urandom), 32'($urandom), 8'($urandom), 1'b0, 1'b0);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 7) == 0)
                    drive(1'b0, 1'b0, 1'b0, 32'd0, 8'd0, 1'b0, 1'b0);
                drive(1'b1, (k == 0) || ($urandom_range(0, 60) == 0), k == len - 1,
                      wide ? 32'($urandom) : 32'($urandom_range(0, 20)), 8'($urandom), 1'($urandom), 1'b0);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0, 8'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/beam_pwr_sort_top16.md
# beam_pwr_sort_top16

Streaming top-16 beam power sorter. It sits directly upstream of the beam pick stage. It consumes one per-beam power value per clock for an RBG (resource block group) packet and maintains a descending-ordered 16-entry list by single-cycle parallel insertion. At packet end it presents the sorted powers and beam indices as the `sort_pwr` / `sort_idx` / `sort_sop` / `rbg_load` bundle that the pick stage uses to select beams from its buffers.

## Interface
Parameters:
- NUM_BEAMS, 64, maximum beats per packet; beats beyond this are ignored and flagged
- PWR_WIDTH, 32, unsigned power width

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_pwr_vld  in  1  beat valid
- i_pwr_sop  in  1  first beat of packet (qualified by i_pwr_vld)
- i_pwr_eop  in  1  last beat of packet (qualified by i_pwr_vld)
- i_pwr  in  PWR_WIDTH  beam power, unsigned
- i_pwr_idx  in  8  beam index of this beat
- i_rbg_load  in  1  RBG load flag, sampled on the eop beat
- o_sort_pwr  out  [15:0][PWR_WIDTH-1:0]  sorted powers; slot 0 is the largest
- o_sort_idx  out  [15:0][7:0]  beam index per slot
- o_sort_cnt  out  5  number of valid slots, 0..16
- o_sort_sop  out  1  one-cycle pulse; outputs updated this cycle
- o_rbg_load  out  1  sampled i_rbg_load, aligned with o_sort_sop
- o_err  out  1  one-cycle pulse on a protocol violation

## Operation
- **States.**
  - IDLE → ACC on a valid beat with sop=1 and eop=0.
  - ACC → IDLE on a valid beat with eop=1.
  - A valid beat with sop=1 and eop=1 is a one-beat packet and stays in or returns to IDLE.
- **List.** 16 entries, each {pwr, idx, used}, kept in descending pwr order.
- **Insertion.** Happens on every accepted beat.
  - gt[k] = !used[k] || (i_pwr > pwr[k]), strict unsigned compare.
  - Position p = lowest k with gt[k].
  - Entries p..14 shift to p+1..15, entry 15 is dropped, and the new beat is written at p.
  - If no gt[k] is set, the beat is discarded.
- **Ties.** Stable: an equal power inserts after existing equals, so the earlier arrival ranks higher.
- **sop beat.** The list is treated as empty before inserting, so the sop beat always lands in slot 0.
- **Accepted beats.**
  - The sop beat.
  - Valid beats in ACC while the beat counter is below NUM_BEAMS.
  - Valid non-sop beats in IDLE are dropped and pulse o_err.
- **sop while in ACC.** Restart: the list is cleared, the new beat is inserted, o_err pulses, and no o_sort_sop is issued for the aborted packet.
- **Beat overflow.** A beat arriving when the counter has already reached NUM_BEAMS is dropped and pulses o_err. If it is also the eop beat, the packet still completes normally.
- **Packet completion (eop).**
  - The output registers load the post-insertion list.
  - Unused slots output pwr=0 and idx=8'hFF.
  - o_sort_cnt = min(accepted beats, 16).
  - o_rbg_load = i_rbg_load sampled on the eop beat.
  - o_sort_sop = 1.
- **Output hold.** Outputs hold until the next packet completes. List accumulation for the next packet never disturbs the outputs.
- **Reset.** Clears the list, state returns to IDLE, the beat counter clears, and all outputs go to 0, including o_sort_idx=0. Reset overrides any simultaneous beat; no output pulse is issued.

## Timing
- **Throughput.** One beat per clock, with no back-pressure; i_pwr_vld may be high every cycle.
- **Latency.** An eop beat sampled at edge T makes o_sort_sop high for exactly the cycle after T. All of o_sort_pwr, o_sort_idx, o_sort_cnt and o_rbg_load are valid in that same cycle.
- **Back-to-back packets.** An eop at edge T followed by a sop at edge T+1 is legal. The sop beat's clear and insert do not affect the outputs presented after T.
- **Internal critical path.** 16 parallel 32-bit compares, priority encode, then a 16-way mux into the list registers. This is a single cycle; do not pipeline.
- **Downstream alignment.** The pick stage consumes o_sort_* on o_sort_sop. It delays the sorted powers and o_rbg_load by 4 cycles itself, so no extra delay is needed here.

## Test plan
- **Ascending 64-beam packet:** idx k, pwr = 100·k for k = 0..63 → slot 0 = {6300, 63} … slot 15 = {4800, 48}; o_sort_cnt = 16; one o_sort_sop pulse the cycle after eop.
- **Ties:** 20 beats, all pwr = 5, idx 0..19 → slots hold idx 0..15 in order, each with pwr 5.
- **Short packet:** 10 beats, pwr = {7, 3, 9, 1, 9, 0, 2, 8, 4, 6}, idx 0..9.
  - Slots 0..9 = pwr {9, 9, 8, 7, 6, 4, 3, 2, 1, 0} with idx {2, 4, 7, 0, 9, 8, 1, 6, 3, 5}.
  - Slots 10..15 = {0, 8'hFF}; o_sort_cnt = 10.
- **Protocol errors:**
  - sop mid-packet → o_err pulse, and the restarted packet's result contains only its own beats.
  - A valid non-sop beat in IDLE → o_err pulse, and the outputs are unchanged.
  - 70 beats with eop on beat 70 → o_err pulses on beats 65..70, and the result reflects beats 1..64 only.
- **Back-to-back packets:** eop then sop on the next cycle with i_rbg_load = 1 then 0 → two o_sort_sop pulses, o_rbg_load = 1 then 0, and each result is independent.
- **Reset mid-packet:** assert i_reset for 1 cycle at beat 30 → no o_sort_sop and all outputs 0. A following full packet then sorts correctly.
